code_entry_buffer: RTL and testbench

CODE_ENTRY_BUFFER -- requirements
Module: code_entry_buffer

---
 rtl/code_entry_buffer_if.sv | 37 +++
 rtl/code_entry_buffer.sv | 135 +++++++++++++
 tb/tb_code_entry_buffer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/code_entry_buffer_if.sv
// Keypad code-entry bus: keypad/consumer strobes in, live entry and committed entry out.
interface code_entry_buffer_if #(
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned MAX_DIGITS = 6
);
  localparam int unsigned LEN_W  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned CODE_W = DIGIT_W * MAX_DIGITS;

  // Keypad and consumer side
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               backspace;
  logic               clear;
  logic               commit;
  logic               commit_ready;

  // Live entry
  logic [CODE_W-1:0]  code;
  logic [LEN_W-1:0]   length;
  logic               full;
  logic               overflow;

  // Committed entry handed to the consumer
  logic               commit_valid;
  logic [CODE_W-1:0]  commit_code;
  logic [LEN_W-1:0]   commit_len;

  modport master (
    output digit_valid, digit, backspace, clear, commit, commit_ready,
    input  code, length, full, overflow, commit_valid, commit_code, commit_len
  );

  modport slave (
    input  digit_valid, digit, backspace, clear, commit, commit_ready,
    output code, length, full, overflow, commit_valid, commit_code, commit_len
  );
endinterface

// File: rtl/code_entry_buffer.sv
// Code entry buffer: collects keypad digits into a shift register, supports
// backspace/clear, and hands a finished entry to a consumer over a
// valid/ready handshake. All outputs come straight from registers.
module code_entry_buffer #(
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned MAX_DIGITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  code_entry_buffer_if.slave bus
);
  localparam int unsigned LEN_W  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned CODE_W = DIGIT_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CODE_W-1:0]  r_code;
  logic [LEN_W-1:0]   r_length;
  logic               r_full;
  logic               r_overflow;
  logic               r_commit_valid;
  logic [CODE_W-1:0]  r_commit_code;
  logic [LEN_W-1:0]   r_commit_len;

  // Combinational helpers for the shift operations
  logic [CODE_W-1:0]  w_code_push;
  logic [CODE_W-1:0]  w_code_pop;
  logic               w_commit_ok;
  logic               w_last_slot;
  logic               w_last_digit;

  // Newest digit enters at the bottom; the oldest digit falls off the top
  assign w_code_push  = {r_code[CODE_W-DIGIT_W-1:0], bus.digit};
  assign w_code_pop   = r_code >> DIGIT_W;
  // A commit is only taken with something to hand over and the consumer slot free
  assign w_commit_ok  = (r_state != S_EMPTY) && !r_commit_valid;
  assign w_last_slot  = (r_length == LEN_W'(MAX_DIGITS - 1));
  assign w_last_digit = (r_length == LEN_W'(1));

  // Entry FSM plus commit handshake; strobe priority clear > commit > backspace > digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_EMPTY;
      r_code         <= '0;
      r_length       <= '0;
      r_full         <= 1'b0;
      r_overflow     <= 1'b0;
      r_commit_valid <= 1'b0;
      r_commit_code  <= '0;
      r_commit_len   <= '0;
    end else begin
      // Consumer side: handshake retires the committed entry, data is kept
      if (r_commit_valid && bus.commit_ready) begin
        r_commit_valid <= 1'b0;
      end

      if (bus.clear) begin
        r_state    <= S_EMPTY;
        r_code     <= '0;
        r_length   <= '0;
        r_full     <= 1'b0;
        r_overflow <= 1'b0;
      end else if (bus.commit && w_commit_ok) begin
        r_commit_valid <= 1'b1;
        r_commit_code  <= r_code;
        r_commit_len   <= r_length;
        r_state        <= S_EMPTY;
        r_code         <= '0;
        r_length       <= '0;
        r_full         <= 1'b0;
        r_overflow     <= 1'b0;
      end else if (bus.backspace) begin
        // Backspace on an empty entry is a no-op that still consumes the cycle
        case (r_state)
          S_EMPTY: begin
          end
          S_ENTRY: begin
            r_code   <= w_code_pop;
            r_length <= r_length - LEN_W'(1);
            if (w_last_digit) begin
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            r_code   <= w_code_pop;
            r_length <= r_length - LEN_W'(1);
            r_state  <= S_ENTRY;
            r_full   <= 1'b0;
          end
          default: begin
            r_state <= S_EMPTY;
          end
        endcase
      end else if (bus.digit_valid) begin
        case (r_state)
          S_EMPTY: begin
            r_code   <= w_code_push;
            r_length <= LEN_W'(1);
            r_state  <= S_ENTRY;
          end
          S_ENTRY: begin
            r_code   <= w_code_push;
            r_length <= r_length + LEN_W'(1);
            if (w_last_slot) begin
              r_state <= S_FULL;
              r_full  <= 1'b1;
            end
          end
          S_FULL: begin
            // Digit offered with no room: entry untouched, flag sticks
            r_overflow <= 1'b1;
          end
          default: begin
            r_state <= S_EMPTY;
          end
        endcase
      end
    end
  end

  // Outputs driven directly from state registers
  assign bus.code         = r_code;
  assign bus.length       = r_length;
  assign bus.full         = r_full;
  assign bus.overflow     = r_overflow;
  assign bus.commit_valid = r_commit_valid;
  assign bus.commit_code  = r_commit_code;
  assign bus.commit_len   = r_commit_len;

endmodule

// File: tb/tb_code_entry_buffer.sv
// Directed bench for code_entry_buffer: default 4x6 instance plus an 8x4 instance.
module tb_code_entry_buffer;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  code_entry_buffer_if #(.DIGIT_W(4), .MAX_DIGITS(6)) bus_a ();
  code_entry_buffer_if #(.DIGIT_W(8), .MAX_DIGITS(4)) bus_b ();

  code_entry_buffer #(.DIGIT_W(4), .MAX_DIGITS(6)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  code_entry_buffer #(.DIGIT_W(8), .MAX_DIGITS(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_a.digit_valid = 1'b0; bus_a.digit = 'x; bus_a.backspace = 1'b0;
    bus_a.clear = 1'b0; bus_a.commit = 1'b0; bus_a.commit_ready = 1'b0;
    bus_b.digit_valid = 1'b0; bus_b.digit = 'x; bus_b.backspace = 1'b0;
    bus_b.clear = 1'b0; bus_b.commit = 1'b0; bus_b.commit_ready = 1'b0;
  endtask

  task automatic digit_a(input logic [3:0] d);
    bus_a.digit_valid = 1'b1; bus_a.digit = d;
    tick();
    bus_a.digit_valid = 1'b0; bus_a.digit = 'x;
  endtask

  task automatic digit_b(input logic [7:0] d);
    bus_b.digit_valid = 1'b1; bus_b.digit = d;
    tick();
    bus_b.digit_valid = 1'b0; bus_b.digit = 'x;
  endtask

  task automatic clear_a();
    bus_a.clear = 1'b1; tick(); bus_a.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_total++; if (bus_a.code !== 24'h0) $display("FAIL rst_code got %h want %h", bus_a.code, 24'h0); else n_pass++;
    n_total++; if (bus_a.length !== 3'd0) $display("FAIL rst_len got %0d want 0", bus_a.length); else n_pass++;
    n_total++; if (bus_a.full !== 1'b0) $display("FAIL rst_full got %b want 0", bus_a.full); else n_pass++;
    n_total++; if (bus_a.overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", bus_a.overflow); else n_pass++;
    n_total++; if (bus_a.commit_valid !== 1'b0) $display("FAIL rst_cvalid got %b want 0", bus_a.commit_valid); else n_pass++;
    n_total++; if (bus_a.commit_code !== 24'h0) $display("FAIL rst_ccode got %h want 0", bus_a.commit_code); else n_pass++;
    n_total++; if (bus_a.commit_len !== 3'd0) $display("FAIL rst_clen got %0d want 0", bus_a.commit_len); else n_pass++;
    n_total++; if (bus_b.code !== 32'h0 || bus_b.length !== 3'd0) $display("FAIL rst_b got code %h len %0d want 0 0", bus_b.code, bus_b.length); else n_pass++;
  endtask

  task automatic test_digits();
    digit_a(4'h1); digit_a(4'h2);
    // Digit value is ignored while digit_valid is low
    bus_a.digit = 4'hF; tick(); bus_a.digit = 'x;
    n_total++; if (bus_a.code !== 24'h000012) $display("FAIL idle_digit got %h want %h", bus_a.code, 24'h000012); else n_pass++;
    digit_a(4'h3);
    n_total++; if (bus_a.code !== 24'h000123) $display("FAIL dig_code got %h want %h", bus_a.code, 24'h000123); else n_pass++;
    n_total++; if (bus_a.length !== 3'd3) $display("FAIL dig_len got %0d want 3", bus_a.length); else n_pass++;
    n_total++; if (bus_a.full !== 1'b0) $display("FAIL dig_full got %b want 0", bus_a.full); else n_pass++;
    clear_a();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) digit_a(4'(i));
    n_total++; if (bus_a.full !== 1'b1 || bus_a.overflow !== 1'b0) $display("FAIL at6 got full %b ovf %b want 1 0", bus_a.full, bus_a.overflow); else n_pass++;
    digit_a(4'h7);
    n_total++; if (bus_a.code !== 24'h123456) $display("FAIL ovf_code got %h want %h", bus_a.code, 24'h123456); else n_pass++;
    n_total++; if (bus_a.length !== 3'd6) $display("FAIL ovf_len got %0d want 6", bus_a.length); else n_pass++;
    n_total++; if (bus_a.full !== 1'b1) $display("FAIL ovf_full got %b want 1", bus_a.full); else n_pass++;
    n_total++; if (bus_a.overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", bus_a.overflow); else n_pass++;
    tick();
    n_total++; if (bus_a.overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus_a.overflow); else n_pass++;
    clear_a();
    n_total++; if (bus_a.code !== 24'h0 || bus_a.length !== 3'd0 || bus_a.full !== 1'b0 || bus_a.overflow !== 1'b0)
      $display("FAIL ovf_clear got code %h len %0d full %b ovf %b want 0 0 0 0", bus_a.code, bus_a.length, bus_a.full, bus_a.overflow);
    else n_pass++;
  endtask

  task automatic test_backspace();
    logic [23:0] exp_code [3];
    logic [2:0]  exp_len  [3];
    exp_code[0] = 24'h000009; exp_code[1] = 24'h0; exp_code[2] = 24'h0;
    exp_len[0]  = 3'd1;       exp_len[1]  = 3'd0; exp_len[2]  = 3'd0;
    digit_a(4'h9); digit_a(4'h8);
    for (int i = 0; i < 3; i++) begin
      bus_a.backspace = 1'b1; tick(); bus_a.backspace = 1'b0;
      n_total++; if (bus_a.code !== exp_code[i] || bus_a.length !== exp_len[i])
        $display("FAIL bs%0d got code %h len %0d want %h %0d", i, bus_a.code, bus_a.length, exp_code[i], exp_len[i]);
      else n_pass++;
    end
  endtask

  task automatic test_commit();
    digit_a(4'hA); digit_a(4'hB);
    bus_a.commit = 1'b1; tick(); bus_a.commit = 1'b0;
    n_total++; if (bus_a.commit_valid !== 1'b1) $display("FAIL cm_valid got %b want 1", bus_a.commit_valid); else n_pass++;
    n_total++; if (bus_a.commit_code !== 24'h0000AB) $display("FAIL cm_code got %h want %h", bus_a.commit_code, 24'h0000AB); else n_pass++;
    n_total++; if (bus_a.commit_len !== 3'd2) $display("FAIL cm_len got %0d want 2", bus_a.commit_len); else n_pass++;
    n_total++; if (bus_a.code !== 24'h0 || bus_a.length !== 3'd0) $display("FAIL cm_entry got %h %0d want 0 0", bus_a.code, bus_a.length); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus_a.commit_valid !== 1'b1 || bus_a.commit_code !== 24'h0000AB || bus_a.commit_len !== 3'd2)
        $display("FAIL cm_hold%0d got %b %h %0d want 1 0000ab 2", i, bus_a.commit_valid, bus_a.commit_code, bus_a.commit_len);
      else n_pass++;
    end
    // Second commit while one is pending is ignored; entry carries on
    digit_a(4'h5);
    bus_a.commit = 1'b1; tick(); bus_a.commit = 1'b0;
    n_total++; if (bus_a.commit_code !== 24'h0000AB || bus_a.code !== 24'h000005 || bus_a.length !== 3'd1)
      $display("FAIL cm_second got ccode %h code %h len %0d want 0000ab 000005 1", bus_a.commit_code, bus_a.code, bus_a.length);
    else n_pass++;
    // Handshake cycle also carries a commit: bubble means it is not taken
    bus_a.commit_ready = 1'b1; bus_a.commit = 1'b1; tick();
    bus_a.commit_ready = 1'b0; bus_a.commit = 1'b0;
    n_total++; if (bus_a.commit_valid !== 1'b0) $display("FAIL hs_valid got %b want 0", bus_a.commit_valid); else n_pass++;
    n_total++; if (bus_a.commit_code !== 24'h0000AB || bus_a.commit_len !== 3'd2) $display("FAIL hs_retain got %h %0d want 0000ab 2", bus_a.commit_code, bus_a.commit_len); else n_pass++;
    n_total++; if (bus_a.code !== 24'h000005 || bus_a.length !== 3'd1) $display("FAIL hs_bubble got %h %0d want 000005 1", bus_a.code, bus_a.length); else n_pass++;
    bus_a.commit = 1'b1; tick(); bus_a.commit = 1'b0;
    n_total++; if (bus_a.commit_valid !== 1'b1 || bus_a.commit_code !== 24'h000005 || bus_a.commit_len !== 3'd1 || bus_a.length !== 3'd0)
      $display("FAIL cm_again got %b %h %0d len %0d want 1 000005 1 0", bus_a.commit_valid, bus_a.commit_code, bus_a.commit_len, bus_a.length);
    else n_pass++;
    bus_a.commit_ready = 1'b1; tick(); bus_a.commit_ready = 1'b0;
  endtask

  task automatic test_priority();
    digit_a(4'h1); digit_a(4'h2);
    bus_a.digit_valid = 1'b1; bus_a.digit = 4'h7; bus_a.backspace = 1'b1; bus_a.commit = 1'b1;
    tick();
    idle_all();
    n_total++; if (bus_a.commit_valid !== 1'b1 || bus_a.commit_len !== 3'd2 || bus_a.commit_code !== 24'h000012)
      $display("FAIL pri_commit got %b %0d %h want 1 2 000012", bus_a.commit_valid, bus_a.commit_len, bus_a.commit_code);
    else n_pass++;
    n_total++; if (bus_a.code !== 24'h0 || bus_a.length !== 3'd0) $display("FAIL pri_drop got %h %0d want 0 0", bus_a.code, bus_a.length); else n_pass++;
    bus_a.commit_ready = 1'b1; tick(); bus_a.commit_ready = 1'b0;
    // Clear beats commit and digit
    digit_a(4'h3);
    bus_a.clear = 1'b1; bus_a.commit = 1'b1; bus_a.digit_valid = 1'b1; bus_a.digit = 4'h4;
    tick();
    idle_all();
    n_total++; if (bus_a.length !== 3'd0 || bus_a.code !== 24'h0 || bus_a.commit_valid !== 1'b0)
      $display("FAIL pri_clear got len %0d code %h cv %b want 0 0 0", bus_a.length, bus_a.code, bus_a.commit_valid);
    else n_pass++;
    // Backspace beats digit
    digit_a(4'h6);
    bus_a.backspace = 1'b1; bus_a.digit_valid = 1'b1; bus_a.digit = 4'h8;
    tick();
    idle_all();
    n_total++; if (bus_a.length !== 3'd0 || bus_a.code !== 24'h0) $display("FAIL pri_bs got len %0d code %h want 0 0", bus_a.length, bus_a.code); else n_pass++;
  endtask

  task automatic test_reset_pending_a();
    digit_a(4'h4);
    bus_a.commit = 1'b1; tick(); bus_a.commit = 1'b0;
    digit_a(4'h2);
    n_total++; if (bus_a.commit_valid !== 1'b1) $display("FAIL rpa_pre got %b want 1", bus_a.commit_valid); else n_pass++;
    rst = 1'b1; bus_a.digit_valid = 1'b1; bus_a.digit = 4'h6; bus_a.commit = 1'b1;
    tick();
    rst = 1'b0; idle_all();
    n_total++; if (bus_a.commit_valid !== 1'b0 || bus_a.commit_code !== 24'h0 || bus_a.commit_len !== 3'd0 || bus_a.length !== 3'd0 || bus_a.code !== 24'h0)
      $display("FAIL rpa got cv %b cc %h cl %0d len %0d code %h want all 0", bus_a.commit_valid, bus_a.commit_code, bus_a.commit_len, bus_a.length, bus_a.code);
    else n_pass++;
  endtask

  task automatic test_reset_pending_b();
    digit_b(8'hAB); digit_b(8'hCD);
    bus_b.commit = 1'b1; tick(); bus_b.commit = 1'b0;
    n_total++; if (bus_b.commit_valid !== 1'b1 || bus_b.commit_code !== 32'h0000ABCD || bus_b.commit_len !== 3'd2)
      $display("FAIL rpb_commit got %b %h %0d want 1 0000abcd 2", bus_b.commit_valid, bus_b.commit_code, bus_b.commit_len);
    else n_pass++;
    digit_b(8'h11); digit_b(8'h22); digit_b(8'h33); digit_b(8'h44);
    n_total++; if (bus_b.code !== 32'h11223344 || bus_b.length !== 3'd4 || bus_b.full !== 1'b1)
      $display("FAIL rpb_full got %h %0d %b want 11223344 4 1", bus_b.code, bus_b.length, bus_b.full);
    else n_pass++;
    digit_b(8'h55);
    n_total++; if (bus_b.overflow !== 1'b1 || bus_b.code !== 32'h11223344)
      $display("FAIL rpb_ovf got %b %h want 1 11223344", bus_b.overflow, bus_b.code);
    else n_pass++;
    rst = 1'b1; bus_b.commit_ready = 1'b0; bus_b.digit_valid = 1'b1; bus_b.digit = 8'h66;
    tick();
    rst = 1'b0; idle_all();
    n_total++; if (bus_b.commit_valid !== 1'b0 || bus_b.commit_code !== 32'h0 || bus_b.length !== 3'd0 || bus_b.full !== 1'b0 || bus_b.overflow !== 1'b0)
      $display("FAIL rpb got cv %b cc %h len %0d full %b ovf %b want all 0", bus_b.commit_valid, bus_b.commit_code, bus_b.length, bus_b.full, bus_b.overflow);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle_all();
    #1;
    test_reset();
    test_digits();
    test_overflow();
    test_backspace();
    test_commit();
    test_priority();
    test_reset_pending_a();
    test_reset_pending_b();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
